// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial pattern generator and its companion sequence detector.
// Holds the FSM state encoding, the default pattern width and the datapath command set.
package sequence_generator_pkg;

    localparam int SEQ_MAX_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_LOAD,
        CMD_STEP,
        CMD_RESTART,
        CMD_GAP_LOAD,
        CMD_GAP_STEP
    } shift_cmd_t;

    // Counter width that stays legal even when the count range collapses to 0 or 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_shift_counter.sv
// Shadow registers, bit/repetition/gap counters and the registered serial bit.
// Driven one command per cycle by the FSM in sequence_generator.
module seq_shift_counter
    import sequence_generator_pkg::*;
#(
    parameter int MAX_LEN    = SEQ_MAX_LEN,
    parameter int GAP_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  shift_cmd_t                     cmd,
    input  logic [MAX_LEN-1:0]             pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic [3:0]                     repeat_cnt,
    output logic                           x,
    output logic                           last_bit,
    output logic                           reps_left,
    output logic                           gap_done
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = idx_width(MAX_LEN);
    localparam int GW = idx_width(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [MAX_LEN-1:0] pat_q;
    logic [IW-1:0]      last_idx_q;
    logic [IW-1:0]      idx_q;
    logic [3:0]         reps_q;
    logic [GW-1:0]      gap_q;
    logic [IW-1:0]      first_idx;
    logic [IW-1:0]      idx_dec;

    assign first_idx = IW'(len - LW'(1));
    assign idx_dec   = idx_q - IW'(1);

    assign last_bit  = (idx_q == '0);
    assign reps_left = (reps_q != '0);
    assign gap_done  = (gap_q == '0);

    // x is loaded with the bit that will be on the line next cycle, so it is a true flop output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q      <= '0;
            last_idx_q <= '0;
            idx_q      <= '0;
            reps_q     <= '0;
            gap_q      <= '0;
            x          <= 1'b0;
        end else begin
            case (cmd)
                CMD_LOAD: begin
                    pat_q      <= pattern;
                    last_idx_q <= first_idx;
                    idx_q      <= first_idx;
                    reps_q     <= repeat_cnt;
                    gap_q      <= '0;
                    x          <= pattern[first_idx];
                end
                CMD_STEP: begin
                    idx_q <= idx_dec;
                    x     <= pat_q[idx_dec];
                end
                CMD_RESTART: begin
                    idx_q  <= last_idx_q;
                    reps_q <= reps_q - 4'd1;
                    x      <= pat_q[last_idx_q];
                end
                CMD_GAP_LOAD: begin
                    gap_q <= GAP_LOAD;
                    x     <= 1'b0;
                end
                CMD_GAP_STEP: begin
                    gap_q <= gap_q - GW'(1);
                    x     <= 1'b0;
                end
                default: begin
                    x <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Burst-mode serial pattern generator: emits len bits MSB-first, repeat_cnt+1 times,
// with optional idle gaps between repetitions and a one-cycle done pulse at the end.
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int MAX_LEN    = SEQ_MAX_LEN,
    parameter int GAP_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [MAX_LEN-1:0]             pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic [3:0]                     repeat_cnt,
    output logic                           x,
    output logic                           valid,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int LW = $clog2(MAX_LEN + 1);

    seq_state_t state, state_nxt;
    shift_cmd_t cmd;
    logic       err_nxt;
    logic       len_ok;
    logic       last_bit;
    logic       reps_left;
    logic       gap_done;

    assign len_ok = (len != '0) && (len <= LW'(MAX_LEN));

    seq_shift_counter #(
        .MAX_LEN    (MAX_LEN),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .pattern    (pattern),
        .len        (len),
        .repeat_cnt (repeat_cnt),
        .x          (x),
        .last_bit   (last_bit),
        .reps_left  (reps_left),
        .gap_done   (gap_done)
    );

    // Status outputs are decoded from the next state so they line up with the registered x.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= (state_nxt == SHIFT);
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd       = CMD_HOLD;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        state_nxt = SHIFT;
                        cmd       = CMD_LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!last_bit) begin
                    cmd = CMD_STEP;
                end else if (reps_left) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                        cmd       = CMD_GAP_LOAD;
                    end else begin
                        cmd = CMD_RESTART;
                    end
                end else begin
                    state_nxt = DONE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (gap_done) begin
                    state_nxt = SHIFT;
                    cmd       = CMD_RESTART;
                end else begin
                    cmd = CMD_GAP_STEP;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench: two generators (no gap, two-cycle gap) share the inputs and are
// compared every cycle against a per-cycle output list built from the burst rules.
module tb_sequence_generator;

    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic [MAX_LEN-1:0]  pattern;
    logic [LW-1:0]       len;
    logic [3:0]          repeat_cnt;

    logic x0, valid0, busy0, done0, err0;
    logic x2, valid2, busy2, done2, err2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] mq[$];
    logic [4:0] exp0[$];
    logic [4:0] exp2[$];
    int         detect0;

    sequence_generator #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
        .len(len), .repeat_cnt(repeat_cnt), .x(x0), .valid(valid0), .busy(busy0),
        .done(done0), .err(err0)
    );

    sequence_generator #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
        .len(len), .repeat_cnt(repeat_cnt), .x(x2), .valid(valid2), .busy(busy2),
        .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    // Output vectors are packed as {err, done, busy, valid, x}.
    task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic [MAX_LEN-1:0] p,
                                 input int ln, input int rc);
        start      = st;
        abort      = ab;
        pattern    = p;
        len        = LW'(ln);
        repeat_cnt = 4'(rc);
    endtask

    // Reference: every cycle of a burst from the first bit through the return to idle.
    task automatic build_expected(input logic [MAX_LEN-1:0] p, input int ln, input int rep,
                                  input int gap);
        mq.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int i = ln - 1; i >= 0; i--)
                mq.push_back({3'b001, 1'b1, p[i]});
            if (r < rep)
                for (int g = 0; g < gap; g++)
                    mq.push_back(5'b00100);
        end
        mq.push_back(5'b01100);
        mq.push_back(5'b00000);
    endtask

    // mode: 0 = plain, 1 = start/input noise mid-burst, 2 = abort at step, 3 = reset at step
    task automatic run_burst(input string name, input logic [MAX_LEN-1:0] p, input int ln,
                             input int rep, input int mode, input int at_step);
        int         nmax, nmin;
        logic [2:0] hist;
        int         nbits;
        logic [4:0] e0, e2;
        build_expected(p, ln, rep, 0);
        exp0 = mq;
        build_expected(p, ln, rep, 2);
        exp2 = mq;
        nmax    = (exp0.size() > exp2.size()) ? exp0.size() : exp2.size();
        nmin    = (exp0.size() < exp2.size()) ? exp0.size() : exp2.size();
        hist    = 3'b000;
        nbits   = 0;
        detect0 = 0;
        applyStimulus(1'b1, 1'b0, p, ln, rep);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, MAX_LEN'($urandom), $urandom_range(0, 9), $urandom_range(0, 15));
        for (int k = 0; k < nmax; k++) begin
            if (mode == 2 && k == at_step) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                checkOutput({name, " g0 after abort"}, {err0, done0, busy0, valid0, x0}, 5'b00000);
                checkOutput({name, " g2 after abort"}, {err2, done2, busy2, valid2, x2}, 5'b00000);
                @(posedge clk); #1;
                checkOutput({name, " g0 idle post abort"}, {err0, done0, busy0, valid0, x0}, 5'b00000);
                return;
            end
            if (mode == 3 && k == at_step) begin
                reset = 1'b1;
                #1;
                checkOutput({name, " g0 async reset"}, {err0, done0, busy0, valid0, x0}, 5'b00000);
                checkOutput({name, " g2 async reset"}, {err2, done2, busy2, valid2, x2}, 5'b00000);
                reset = 1'b0;
                @(posedge clk); #1;
                checkOutput({name, " g0 idle post reset"}, {err0, done0, busy0, valid0, x0}, 5'b00000);
                return;
            end
            e0 = (k < exp0.size()) ? exp0[k] : 5'b00000;
            e2 = (k < exp2.size()) ? exp2[k] : 5'b00000;
            checkOutput($sformatf("%s g0 step %0d", name, k), {err0, done0, busy0, valid0, x0}, e0);
            checkOutput($sformatf("%s g2 step %0d", name, k), {err2, done2, busy2, valid2, x2}, e2);
            if (valid0) begin
                hist = {hist[1:0], x0};
                nbits++;
                if (nbits >= 3 && hist == 3'b110)
                    detect0++;
            end
            if (mode == 1 && k < nmin - 1)
                applyStimulus(1'($urandom_range(0, 1)), 1'b0, MAX_LEN'($urandom),
                              $urandom_range(0, 9), $urandom_range(0, 15));
            else
                start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic err_test(input int ln);
        applyStimulus(1'b1, 1'b0, MAX_LEN'($urandom), ln, $urandom_range(0, 15));
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput($sformatf("err pulse len=%0d g0", ln), {err0, done0, busy0, valid0, x0}, 5'b10000);
        checkOutput($sformatf("err pulse len=%0d g2", ln), {err2, done2, busy2, valid2, x2}, 5'b10000);
        @(posedge clk); #1;
        checkOutput($sformatf("err clear len=%0d g0", ln), {err0, done0, busy0, valid0, x0}, 5'b00000);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 0, 0);
        #12;
        checkOutput("reset state g0", {err0, done0, busy0, valid0, x0}, 5'b00000);
        checkOutput("reset state g2", {err2, done2, busy2, valid2, x2}, 5'b00000);
        #1 reset = 1'b0;

        run_burst("single", 8'b00110110, 6, 0, 0, 0);
        run_burst("repeat", 8'b00110110, 6, 1, 0, 0);
        checkCount("detect 110 count", detect0, 4);
        run_burst("gap", 8'b00000101, 3, 1, 0, 0);

        err_test(0);
        err_test(9);

        applyStimulus(1'b1, 1'b1, 8'hA5, 4, 0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, '0, 0, 0);
        checkOutput("abort beats start g0", {err0, done0, busy0, valid0, x0}, 5'b00000);
        checkOutput("abort beats start g2", {err2, done2, busy2, valid2, x2}, 5'b00000);

        run_burst("abort", MAX_LEN'($urandom), 5, 1, 2, 2);
        run_burst("after abort", 8'b11001010, 4, 1, 0, 0);
        run_burst("reset mid", MAX_LEN'($urandom), 6, 2, 3, 4);
        run_burst("after reset", 8'b01011100, 5, 0, 0, 0);
        run_burst("noise", 8'b10010110, 7, 2, 1, 0);

        for (int t = 0; t < 12; t++)
            run_burst($sformatf("rand%0d", t), MAX_LEN'($urandom), $urandom_range(1, MAX_LEN),
                      $urandom_range(0, 3), 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits.
REQ-002 Parameter GAP_CYCLES, default 0, idle cycles inserted between pattern repetitions.
REQ-003 clk  input  1  single system clock; all state changes SHALL occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a burst, sampled only in IDLE.
REQ-006 abort  input  1  request to terminate the current burst.
REQ-007 pattern  input  MAX_LEN  bit pattern to emit; bit len-1 is sent first.
REQ-008 len  input  $clog2(MAX_LEN+1)  number of pattern bits to emit per repetition, legal range 1..MAX_LEN.
REQ-009 repeat_cnt  input  4  number of additional repetitions, 0..15.
REQ-010 x  output  1  serial data bit, the same signal a sequence detector consumes.
REQ-011 valid  output  1  x carries a pattern bit this cycle.
REQ-012 busy  output  1  a burst is in progress.
REQ-013 done  output  1  one-cycle pulse at normal burst completion.
REQ-014 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, GAP and DONE.
REQ-016 In IDLE with start=1 and len in 1..MAX_LEN, the block SHALL capture pattern, len and repeat_cnt into shadow registers and enter SHIFT on that edge.
REQ-017 All outputs SHALL be registered, so x=pattern[len-1] with valid=1 appears in the first cycle after the start edge.
REQ-018 In SHIFT, each edge SHALL advance one bit, MSB-first, through bit 0.
REQ-019 Inputs SHALL be ignored after capture; changing pattern, len or repeat_cnt mid-burst SHALL have no effect.
REQ-020 After bit 0, if repetitions remain and GAP_CYCLES>0, the FSM SHALL enter GAP with valid=0 and x=0 for exactly GAP_CYCLES cycles, then return to SHIFT.
REQ-021 After bit 0, if repetitions remain and GAP_CYCLES=0, bit len-1 SHALL follow in the next cycle with no bubble.
REQ-022 After bit 0 of the final repetition, the FSM SHALL spend one cycle in DONE with done=1, valid=0 and x=0, then return to IDLE.
REQ-023 Total valid cycles per burst SHALL be len*(repeat_cnt+1).
REQ-024 busy SHALL be 1 in SHIFT, GAP and DONE, and 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored, including start during DONE.
REQ-026 start in IDLE with len=0 or len>MAX_LEN SHALL pulse err for one cycle and remain in IDLE with no valid output.
REQ-027 abort=1 in SHIFT, GAP or DONE SHALL return the FSM to IDLE on that edge, with valid, busy and done all 0 next cycle and no done pulse.
REQ-028 abort=1 in IDLE SHALL have no effect; abort takes priority over start.
REQ-029 x SHALL be 0 whenever valid=0.
REQ-030 Bit and repetition counters SHALL not wrap; the repetition counter SHALL be at least 4 bits wide, the bit counter at least $clog2(MAX_LEN) bits wide.

Reset
REQ-031 reset=1 SHALL immediately, asynchronously, force IDLE and drive x=0, valid=0, busy=0, done=0 and err=0, and clear all counters and shadow registers.
REQ-032 Reset asserted mid-burst SHALL discard the burst; after release the block SHALL wait for a new start.
REQ-033 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-034 The FSM state typedef/encoding and the MAX_LEN default SHALL live in a shared package, also used by sequence_detector.
REQ-035 The shift and counter datapath MAY be split into one sub-module, seq_shift_counter, with the FSM in the top level.

Verification
REQ-036 MAX_LEN=8, pattern=8'b00110110, len=6, repeat_cnt=0, start -> x=1,1,0,1,1,0 with valid=1 on the next 6 cycles, then done=1 for 1 cycle.
REQ-037 Same burst with repeat_cnt=1 and GAP_CYCLES=0 -> 12 contiguous valid bits 110110110110; a sequence_detector for 110 attached to x SHALL assert z 4 times.
REQ-038 GAP_CYCLES=2, len=3, pattern=3'b101, repeat_cnt=1 -> valid pattern 1,1,1,0,0,1,1,1 (x=1,0,1,-,-,1,0,1), then done.
REQ-039 start with len=0, and separately len=9 -> err pulses once, busy stays 0, no valid.
REQ-040 abort asserted on the 3rd bit, and separately reset pulsed mid-burst -> next cycle valid=0, busy=0, no done; a fresh start then runs normally.
REQ-041 Second start pulsed during busy and during DONE -> ignored, bit count unchanged.
